// File: rtl/gameport_ctrl.sv
// Game port controller: decodes one I/O port, triggers the joystick timing
// core on a write, watches the axis one-shots until they all fall or a
// timeout expires, and returns the raw joystick status on a read.
module gameport_ctrl #(
  parameter logic [15:0] PORT_ADDR = 16'h0201,
  parameter logic [16:0] TIMEOUT   = 17'd70000,
  parameter int          EN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] io_addr,
  input  logic        io_wr,
  input  logic        io_rd,
  output logic [7:0]  io_dout,
  output logic        io_dout_valid,
  input  logic [7:0]  joy_d,
  input  logic [3:0]  axis_mask,
  output logic        joy_en,
  output logic        busy,
  output logic        timeout_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Number of joy_en cycles that make up one trigger pulse.
  localparam logic [2:0] EN_LAST = 3'(EN_CYCLES);

  state_e      state_r;
  state_e      state_s;
  logic [16:0] cnt_r;
  logic [16:0] cnt_s;
  logic [16:0] cnt_inc_s;
  logic [2:0]  en_cnt_r;
  logic [2:0]  en_cnt_s;
  logic        joy_en_r;
  logic        joy_en_s;
  logic        settle_r;
  logic        settle_s;
  logic        timeout_r;
  logic        timeout_s;
  logic        busy_r;
  logic [7:0]  io_dout_r;
  logic        io_dout_valid_r;
  logic        wr_hit_s;
  logic        rd_hit_s;
  logic [3:0]  axes_live_s;

  assign wr_hit_s    = io_wr && (io_addr == PORT_ADDR);
  assign rd_hit_s    = io_rd && (io_addr == PORT_ADDR);
  // Axes that still count towards completion; masked axes are ignored.
  assign axes_live_s = joy_d[3:0] & ~axis_mask;
  // The measurement counter saturates at TIMEOUT instead of wrapping.
  assign cnt_inc_s   = (cnt_r == TIMEOUT) ? cnt_r : (cnt_r + 17'd1);

  // Next-state logic: trigger/restart handling, pulse sequencing, completion.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    en_cnt_s  = en_cnt_r;
    joy_en_s  = 1'b0;
    settle_s  = 1'b0;
    timeout_s = timeout_r;
    if (wr_hit_s) begin
      // A write always (re)starts a measurement from scratch.
      state_s   = TRIG;
      cnt_s     = 17'd0;
      timeout_s = 1'b0;
      if (joy_en_r) begin
        // Pulse currently high: insert one low cycle so the core sees a fresh edge.
        joy_en_s = 1'b0;
        en_cnt_s = 3'd0;
      end else begin
        joy_en_s = 1'b1;
        en_cnt_s = 3'd1;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        TRIG: begin
          if (en_cnt_r == EN_LAST) begin
            // Pulse complete; the first RUN cycle is the settle cycle.
            state_s  = RUN;
            settle_s = 1'b1;
          end else begin
            joy_en_s = 1'b1;
            en_cnt_s = en_cnt_r + 3'd1;
          end
        end
        RUN: begin
          cnt_s = cnt_inc_s;
          if (settle_r) begin
            state_s = RUN;
          end else if (axes_live_s == 4'h0) begin
            // Completion has priority over a coincident timeout.
            state_s = DONE;
          end else if (cnt_r == TIMEOUT) begin
            state_s   = DONE;
            timeout_s = 1'b1;
          end else begin
            state_s = RUN;
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Measurement state and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 17'd0;
      en_cnt_r  <= 3'd0;
      joy_en_r  <= 1'b0;
      settle_r  <= 1'b0;
      timeout_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      en_cnt_r  <= en_cnt_s;
      joy_en_r  <= joy_en_s;
      settle_r  <= settle_s;
      timeout_r <= timeout_s;
      busy_r    <= (state_s != IDLE);
    end
  end

  // Read path: capture joy_d in the strobe cycle, present it one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_dout_r       <= 8'hFF;
      io_dout_valid_r <= 1'b0;
    end else if (rd_hit_s) begin
      io_dout_r       <= joy_d;
      io_dout_valid_r <= 1'b1;
    end else begin
      io_dout_r       <= 8'hFF;
      io_dout_valid_r <= 1'b0;
    end
  end

  assign io_dout       = io_dout_r;
  assign io_dout_valid = io_dout_valid_r;
  assign joy_en        = joy_en_r;
  assign busy          = busy_r;
  assign timeout_flag  = timeout_r;

  gameport_ctrl_chk u_chk (
    .clk           (clk),
    .reset         (reset),
    .io_dout       (io_dout_r),
    .io_dout_valid (io_dout_valid_r),
    .joy_en        (joy_en_r),
    .busy          (busy_r),
    .timeout_flag  (timeout_r)
  );

endmodule

// Output invariants of the game port controller.
module gameport_ctrl_chk (
  input logic       clk,
  input logic       reset,
  input logic [7:0] io_dout,
  input logic       io_dout_valid,
  input logic       joy_en,
  input logic       busy,
  input logic       timeout_flag
);

  // Read data bus idles at all-ones.
  a_dout_idle: assert property (@(posedge clk) disable iff (reset)
    !io_dout_valid |-> (io_dout == 8'hFF));

  // The trigger is only ever driven while a measurement is in progress.
  a_en_busy: assert property (@(posedge clk) disable iff (reset)
    joy_en |-> busy);

  // A reset cycle leaves every output at its reset value.
  a_reset_vals: assert property (@(posedge clk)
    reset |=> (!busy && !joy_en && !io_dout_valid && !timeout_flag && (io_dout == 8'hFF)));

endmodule
